// File: rtl/element_delay_tracker.sv
// Tracks per-side integer sample delays by walking d until the squared-residual falls within +/-d,
// then hands one (pos, neg) delay pair per element to the delay-line stage over a valid/ack handshake.
module element_delay_tracker #(
    parameter int DW_INPUT    = 8,
    parameter int DW_INTEGER  = 18,
    parameter int DW_FRACTION = 6,
    parameter int DW_DELAY    = 14,
    parameter int MAX_STEPS   = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   initiate,
    input  logic [DW_INPUT+3:0]                    r_0,
    input  logic signed [DW_INTEGER+DW_FRACTION:0] term_pos_n,
    input  logic signed [DW_INTEGER+DW_FRACTION:0] term_neg_n,
    input  logic                                   term_ready,
    input  logic                                   term_last,
    output logic                                   term_ack,
    output logic [DW_DELAY-1:0]                    delay_pos,
    output logic [DW_DELAY-1:0]                    delay_neg,
    output logic [5:0]                             element_idx,
    output logic                                   delay_valid,
    input  logic                                   delay_ack,
    output logic                                   done,
    output logic                                   overflow
);

    localparam int EW = DW_INTEGER + DW_FRACTION + 3;
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam logic [DW_DELAY-1:0] D_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OUT,
        S_WAIT_TERM,
        S_ADJUST
    } state_t;

    typedef struct packed {
        logic signed [EW-1:0] e;
        logic [DW_DELAY-1:0]  d;
        logic                 settled;
        logic                 blocked;
    } side_t;

    state_t               state;
    logic [DW_INPUT+3:0]  r0_q;
    logic signed [EW-1:0] e_pos, e_neg;
    logic [DW_DELAY-1:0]  d_pos, d_neg;
    logic [5:0]           idx;
    logic                 last_r;
    logic [SW-1:0]        step_cnt;
    side_t                adj_pos, adj_neg;

    // One +/-1 move of d; the residual tracks target - d^2, so moving d by one
    // subtracts or adds the difference of consecutive squares (2d+1 or 2d-1).
    function automatic side_t adjust_side(input logic signed [EW-1:0] e,
                                          input logic [DW_DELAY-1:0]  d);
        side_t                r;
        logic signed [EW-1:0] d_scaled;
        logic signed [EW-1:0] step_up;
        logic signed [EW-1:0] step_dn;
        d_scaled  = EW'({d, {DW_FRACTION{1'b0}}});
        step_up   = EW'({d, 1'b1, {DW_FRACTION{1'b0}}});
        step_dn   = EW'({d - D_ONE, 1'b1, {DW_FRACTION{1'b0}}});
        r.e       = e;
        r.d       = d;
        r.settled = 1'b1;
        r.blocked = 1'b0;
        if (e > d_scaled) begin
            if (&d) begin
                r.blocked = 1'b1;
            end else begin
                r.e       = e - step_up;
                r.d       = d + D_ONE;
                r.settled = 1'b0;
            end
        end else if (e < -d_scaled) begin
            if (d == '0) begin
                r.blocked = 1'b1;
            end else begin
                r.e       = e + step_dn;
                r.d       = d - D_ONE;
                r.settled = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        adj_pos = adjust_side(e_pos, d_pos);
        adj_neg = adjust_side(e_neg, d_neg);
    end

    // Pulses (term_ack, done) default low every cycle; outputs are only loaded on entry to OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            r0_q        <= '0;
            e_pos       <= '0;
            e_neg       <= '0;
            d_pos       <= '0;
            d_neg       <= '0;
            idx         <= '0;
            last_r      <= 1'b0;
            step_cnt    <= '0;
            term_ack    <= 1'b0;
            delay_pos   <= '0;
            delay_neg   <= '0;
            element_idx <= '0;
            delay_valid <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            term_ack <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (initiate) begin
                        r0_q     <= r_0;
                        overflow <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    d_pos       <= DW_DELAY'(r0_q);
                    d_neg       <= DW_DELAY'(r0_q);
                    e_pos       <= '0;
                    e_neg       <= '0;
                    idx         <= '0;
                    last_r      <= 1'b0;
                    delay_pos   <= DW_DELAY'(r0_q);
                    delay_neg   <= DW_DELAY'(r0_q);
                    element_idx <= '0;
                    delay_valid <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (delay_ack) begin
                        delay_valid <= 1'b0;
                        if (last_r) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_WAIT_TERM;
                        end
                    end
                end
                S_WAIT_TERM: begin
                    if (term_ready) begin
                        e_pos    <= e_pos + EW'(term_pos_n);
                        e_neg    <= e_neg + EW'(term_neg_n);
                        last_r   <= term_last;
                        idx      <= idx + 6'd1;
                        term_ack <= 1'b1;
                        step_cnt <= '0;
                        state    <= S_ADJUST;
                    end
                end
                S_ADJUST: begin
                    if (adj_pos.blocked || adj_neg.blocked) begin
                        overflow <= 1'b1;
                    end
                    if (adj_pos.settled && adj_neg.settled) begin
                        delay_pos   <= d_pos;
                        delay_neg   <= d_neg;
                        element_idx <= idx;
                        delay_valid <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        e_pos    <= adj_pos.e;
                        e_neg    <= adj_neg.e;
                        d_pos    <= adj_pos.d;
                        d_neg    <= adj_neg.d;
                        step_cnt <= step_cnt + SW'(1);
                        // Step budget exhausted: publish wherever d has got to and flag it.
                        if (step_cnt == SW'(MAX_STEPS - 1)) begin
                            overflow    <= 1'b1;
                            delay_pos   <= adj_pos.d;
                            delay_neg   <= adj_neg.d;
                            element_idx <= idx;
                            delay_valid <= 1'b1;
                            state       <= S_OUT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_element_delay_tracker.sv
// Directed and randomized bench for element_delay_tracker; the reference model tracks each side's
// target squared delay and finds the settled d from the square thresholds directly.
`timescale 1ns/1ps
module tb_element_delay_tracker;

    localparam int MAX_STEPS = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               initiate = 1'b0;
    logic [11:0]        r_0 = '0;
    logic signed [24:0] term_pos_n = '0;
    logic signed [24:0] term_neg_n = '0;
    logic               term_ready = 1'b0;
    logic               term_last = 1'b0;
    logic               delay_ack = 1'b0;
    logic               term_ack, delay_valid, done, overflow;
    logic [13:0]        delay_pos, delay_neg;
    logic [5:0]         element_idx;

    int     checks = 0;
    int     failures = 0;
    longint t_pos, t_neg;
    int     md_pos, md_neg, m_idx, exp_lat;
    bit     m_ovf, m_last;

    element_delay_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .initiate   (initiate),
        .r_0        (r_0),
        .term_pos_n (term_pos_n),
        .term_neg_n (term_neg_n),
        .term_ready (term_ready),
        .term_last  (term_last),
        .term_ack   (term_ack),
        .delay_pos  (delay_pos),
        .delay_neg  (delay_neg),
        .element_idx(element_idx),
        .delay_valid(delay_valid),
        .delay_ack  (delay_ack),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Settled d: walking up stops at the first d with target <= d^2+d,
    // walking down stops at the first d with target >= d^2-d (targets in 1/64 units).
    function automatic int settle(input longint t, input int d_prev);
        int d = d_prev;
        while (t > 64 * (longint'(d) * d + d)) d++;
        while (d > 0 && t < 64 * (longint'(d) * d - d)) d--;
        return d;
    endfunction

    task automatic applyStimulus(input int kp, input int kn, input bit last);
        int np, nn, sp, sn;
        term_pos_n = 25'(kp);
        term_neg_n = 25'(kn);
        term_last  = last;
        term_ready = 1'b1;
        t_pos += kp;
        t_neg += kn;
        np = settle(t_pos, md_pos);
        nn = settle(t_neg, md_neg);
        sp = (np > md_pos) ? np - md_pos : md_pos - np;
        sn = (nn > md_neg) ? nn - md_neg : md_neg - nn;
        if (t_pos < 0 && sp < MAX_STEPS) m_ovf = 1'b1;
        if (t_neg < 0 && sn < MAX_STEPS) m_ovf = 1'b1;
        md_pos = (sp >= MAX_STEPS) ? ((np > md_pos) ? md_pos + MAX_STEPS : md_pos - MAX_STEPS) : np;
        md_neg = (sn >= MAX_STEPS) ? ((nn > md_neg) ? md_neg + MAX_STEPS : md_neg - MAX_STEPS) : nn;
        if (sp >= MAX_STEPS || sn >= MAX_STEPS) begin
            m_ovf   = 1'b1;
            exp_lat = MAX_STEPS;
        end else begin
            exp_lat = ((sp > sn) ? sp : sn) + 1;
        end
        m_idx++;
        m_last = last;
    endtask

    task automatic wait_valid(input string tag, input int lat);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!delay_valid && n < 200);
        checkOutput({tag, "_valid"}, delay_valid, 1);
        checkOutput({tag, "_lat"}, n, lat);
        checkOutput({tag, "_pos"}, delay_pos, md_pos);
        checkOutput({tag, "_neg"}, delay_neg, md_neg);
        checkOutput({tag, "_idx"}, element_idx, m_idx);
        checkOutput({tag, "_ovf"}, overflow, m_ovf);
    endtask

    task automatic finish_term(input string tag);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!term_ack && n < 200);
        checkOutput({tag, "_ack_lat"}, n, 1);
        term_ready = 1'b0;
        wait_valid(tag, exp_lat);
    endtask

    task automatic ack_output(input string tag);
        delay_ack = 1'b1;
        @(posedge clk); #1;
        delay_ack = 1'b0;
        checkOutput({tag, "_vdrop"}, delay_valid, 0);
        checkOutput({tag, "_done"}, done, m_last);
        if (m_last) begin
            @(posedge clk); #1;
            checkOutput({tag, "_done_pulse"}, done, 0);
        end
    endtask

    task automatic start_run(input int r0);
        t_pos  = 64 * longint'(r0) * r0;
        t_neg  = t_pos;
        md_pos = r0;
        md_neg = r0;
        m_idx  = 0;
        m_ovf  = 1'b0;
        m_last = 1'b0;
        initiate = 1'b1;
        r_0      = 12'(r0);
        @(posedge clk); #1;
        initiate = 1'b0;
        checkOutput("init_ovf_clr", overflow, 0);
        wait_valid("elem0", 1);
    endtask

    initial begin
        int kp, kn, n;
        $display("[TB] element_delay_tracker bench start");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", delay_valid, 0);
        checkOutput("rst_pos", delay_pos, 0);
        checkOutput("rst_idx", element_idx, 0);
        checkOutput("rst_ack", term_ack, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero terms: every element sits at r_0; element 5 also exercises a stalled consumer.
        start_run(100);
        for (int i = 0; i < 33; i++) begin
            if (i == 5) begin
                applyStimulus(0, 0, 1'b0);
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk); #1;
                    checkOutput("hold_ack", term_ack, 0);
                    checkOutput("hold_valid", delay_valid, 1);
                    checkOutput("hold_pos", delay_pos, 100);
                    checkOutput("hold_idx", element_idx, 5);
                end
                ack_output("t1");
                finish_term("t1");
            end else begin
                ack_output("t1");
                applyStimulus(0, 0, i == 32);
                finish_term("t1");
            end
        end
        checkOutput("t1_final_idx", element_idx, 33);
        ack_output("t1_last");

        // K = 16.46875*(2n+1) from d=0: delays 4, 8, 12.
        start_run(0);
        ack_output("t2");
        applyStimulus(1054, 1054, 1'b0);
        finish_term("t2n1");
        checkOutput("t2_d1", delay_pos, 4);
        ack_output("t2");
        applyStimulus(3162, 3162, 1'b0);
        finish_term("t2n2");
        checkOutput("t2_d2", delay_neg, 8);
        ack_output("t2");
        applyStimulus(5270, 5270, 1'b1);
        finish_term("t2n3");
        checkOutput("t2_d3", delay_pos, 12);
        ack_output("t2_last");

        // One step each way from 100.
        start_run(100);
        ack_output("t3");
        applyStimulus(12864, -12736, 1'b1);
        finish_term("t3");
        checkOutput("t3_pos", delay_pos, 101);
        checkOutput("t3_neg", delay_neg, 99);
        ack_output("t3_last");

        // Huge K runs out of steps; the next initiate clears the sticky flag.
        start_run(0);
        ack_output("t6");
        applyStimulus(6400000, 6400000, 1'b1);
        finish_term("t6");
        checkOutput("t6_ovf", overflow, 1);
        checkOutput("t6_pos", delay_pos, 64);
        ack_output("t6_last");
        start_run(5);
        ack_output("t6b");
        applyStimulus(0, 0, 1'b1);
        finish_term("t6b");
        ack_output("t6b_last");

        // Randomized full-length runs.
        for (int run = 0; run < 2; run++) begin
            start_run(int'($urandom_range(50, 1000)));
            for (int i = 0; i < 33; i++) begin
                ack_output("rnd");
                kp = int'($urandom_range(0, 64 * (6 * md_pos + 6))) - 32 * md_pos;
                kn = int'($urandom_range(0, 64 * (6 * md_neg + 6))) - 32 * md_neg;
                applyStimulus(kp, kn, i == 32);
                finish_term("rnd");
            end
            ack_output("rnd_last");
        end

        // Reset in the middle of a long adjustment.
        start_run(10);
        ack_output("t5");
        applyStimulus(6400000, 6400000, 1'b1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!term_ack && n < 200);
        checkOutput("t5_ack", term_ack, 1);
        term_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t5_valid", delay_valid, 0);
        checkOutput("t5_pos", delay_pos, 0);
        checkOutput("t5_neg", delay_neg, 0);
        checkOutput("t5_idx", element_idx, 0);
        checkOutput("t5_ovf", overflow, 0);
        checkOutput("t5_done", done, 0);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("t5_idle", delay_valid, 0);
        end
        start_run(77);
        ack_output("t5b");
        applyStimulus(64 * 155, 64 * 155, 1'b1);
        finish_term("t5b");
        ack_output("t5b_last");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
